bayer_stream_source: RTL and testbench
======================================

Name: bayer_stream_source

Overview:
Synthetic D8M-style raw pixel stream transmitter: drives CCD_DATA / CCD_FVAL / CCD_LVAL exactly as the camera bridge does, so the raw-to-RGB path and the VGA sync logic can be exercised without the D8M board. It runs in the pixel clock domain and is selected in place of MIPI_PIXEL_D / HS / VS at the top level. It emits a GRBG Bayer mosaic of one of four test patterns.

Parameters:
H_ACTIVE, 640, active pixels per line (LVAL high cycles); must be a multiple of 8
H_BLANK, 160, LVAL-low cycles after each active line
V_ACTIVE, 480, active lines per frame
V_BLANK, 45, full-length lines (H_ACTIVE+H_BLANK cycles) with FVAL low between frames
FV_LEAD, 4, cycles FVAL high before first LVAL of a frame
FV_TAIL, 4, cycles FVAL stays high after last line's blank completes

Ports:
CCD_PIXCLK  in  1  pixel clock, all logic on rising edge
RESET_SYS_N  in  1  asynchronous active-low reset
src_enable  in  1  level; start/continue frames
pattern_sel  in  2  0 solid, 1 ramp, 2 colour bars, 3 checker
solid_level  in  10  value for pattern 0
CCD_DATA  out  10  raw Bayer sample
CCD_FVAL  out  1  frame valid
CCD_LVAL  out  1  line valid
src_xcont  out  13  active pixel column, 0..H_ACTIVE-1
src_ycont  out  13  active line, 0..V_ACTIVE-1
frame_done  out  1  one-cycle pulse after FV_TAIL ends
src_busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; frame counter 0.
- All outputs registered; CCD_DATA, src_xcont and src_ycont are valid in the same cycle as CCD_LVAL=1. CCD_DATA is 0 whenever LVAL=0.
- States:
  - IDLE: wait for src_enable=1, then go to LEAD and latch pattern_sel and solid_level for the whole frame.
  - LEAD: FVAL=1, LVAL=0 for FV_LEAD cycles, then ACTIVE.
  - ACTIVE: LVAL=1 for H_ACTIVE cycles; x counts 0..H_ACTIVE-1, then HBLANK.
  - HBLANK: FVAL=1, LVAL=0 for H_BLANK cycles. If y<V_ACTIVE-1: y++ and go to ACTIVE. Otherwise go to TAIL.
  - TAIL: FVAL=1 for FV_TAIL cycles, then pulse frame_done, increment the frame counter (8-bit, wraps), and go to VBLANK.
  - VBLANK: FVAL=0 for V_BLANK*(H_ACTIVE+H_BLANK) cycles. Then go to LEAD if src_enable=1, else IDLE.
- src_enable deasserted mid-frame: the current frame completes unchanged, then VBLANK, then IDLE. Frames are never truncated.
- Changes to pattern_sel or solid_level mid-frame have no effect until the next LEAD.
- Bayer order: even y → even x G, odd x R; odd y → even x B, odd x G. CCD_DATA is the selected component of the pattern RGB.
- Patterns (10-bit components):
  - 0: R=G=B=solid_level.
  - 1: each component = x[9:0], truncated.
  - 2: bar index b = x/(H_ACTIVE/8), produced by a bar-width counter (no divider). R=b[2], G=b[1], B=b[0], each mapped to 10'h3FF or 0.
  - 3: all components = 10'h3FF when x[4]^y[4]^frame_cnt[0] is 1, else 0.
- src_xcont and src_ycont hold their last values outside ACTIVE.

Optional Feature:
- Macro SRC_LFSR_NOISE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances each ACTIVE cycle. CCD_DATA[1:0] is XORed with LFSR[1:0] for dither testing.
- Undefined: no LFSR logic; CCD_DATA is the exact pattern value.

Test Plan:
1. H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=2, FV_LEAD=FV_TAIL=2, src_enable=1 → per frame: 4 LVAL pulses of 16 cycles; FVAL high 2+4*20+2=84 cycles, low 40 cycles; frame_done pulses once per frame.
2. pattern 2, H_ACTIVE=16 → row 0 CCD_DATA: x0,x1=(G,R) of bar0 → 0,0; x14=G of bar7 → 3FF; row 1 x2 (B, bar1) → 3FF.
3. pattern 1 → row 0 x=5 (R) → 10'd5; row 1 x=6 (B) → 10'd6.
4. pattern 0, solid_level=10'h155; switch pattern_sel to 2 mid-frame → data stays 155 for the entire frame; next frame shows bars.
5. Drop src_enable at line 2 → frame completes all 4 lines, frame_done pulses, VBLANK completes, then IDLE with src_busy=0 and FVAL=0.
6. Assert RESET_SYS_N low mid-line → all outputs 0 immediately (asynchronous); after release, with src_enable=1, LEAD starts on the first clock edge.

Source files
------------

// File: rtl/bayer_stream_source.sv
// Synthetic D8M-style raw Bayer (GRBG) stream source driving CCD_DATA/FVAL/LVAL.
// Optional build macro SRC_LFSR_NOISE_EN adds LFSR dither on CCD_DATA[1:0].
module bayer_stream_source #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_BLANK  = 45,
    parameter int unsigned FV_LEAD  = 4,
    parameter int unsigned FV_TAIL  = 4
) (
    input  logic        CCD_PIXCLK,
    input  logic        RESET_SYS_N,
    input  logic        src_enable,
    input  logic [1:0]  pattern_sel,
    input  logic [9:0]  solid_level,
    output logic [9:0]  CCD_DATA,
    output logic        CCD_FVAL,
    output logic        CCD_LVAL,
    output logic [12:0] src_xcont,
    output logic [12:0] src_ycont,
    output logic        frame_done,
    output logic        src_busy
);

    localparam int unsigned DATA_W    = 10;
    localparam int unsigned XY_W      = 13;
    localparam int unsigned FCNT_W    = 8;
    localparam int unsigned LINE_LEN  = H_ACTIVE + H_BLANK;
    localparam int unsigned VB_CYC    = V_BLANK * LINE_LEN;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned CNT_MAX_A = (VB_CYC > FV_LEAD) ? VB_CYC : FV_LEAD;
    localparam int unsigned CNT_MAX_B = (H_BLANK > FV_TAIL) ? H_BLANK : FV_TAIL;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BAR_CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CNT_W-1:0]  LEAD_LAST = CNT_W'(FV_LEAD - 1);
    localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  TAIL_LAST = CNT_W'(FV_TAIL - 1);
    localparam logic [CNT_W-1:0]  VB_LAST   = CNT_W'(VB_CYC - 1);
    localparam logic [XY_W-1:0]   X_LAST    = XY_W'(H_ACTIVE - 1);
    localparam logic [XY_W-1:0]   Y_LAST    = XY_W'(V_ACTIVE - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_W - 1);
    localparam logic [DATA_W-1:0] FULL      = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_ACTIVE,
        ST_HBLANK,
        ST_TAIL,
        ST_VBLANK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XY_W-1:0]     x_q, x_d;
    logic [XY_W-1:0]     y_q, y_d;
    logic [BAR_CW-1:0]   bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    logic [1:0]          pat_q, pat_d;
    logic [DATA_W-1:0]   solid_q, solid_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                done_q, done_d;
    logic                fval_q, fval_d;
    logic                lval_q, lval_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   comp_r, comp_g, comp_b;
    logic [DATA_W-1:0]   pix_raw, pix_out;

    // State register and all registered outputs.
    always_ff @(posedge CCD_PIXCLK or negedge RESET_SYS_N) begin
        if (!RESET_SYS_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            fcnt_q    <= '0;
            done_q    <= 1'b0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            fcnt_q    <= fcnt_d;
            done_q    <= done_d;
            fval_q    <= fval_d;
            lval_q    <= lval_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
        end
    end

    // Frame sequencing; outputs are derived from the next state so they line up with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        fcnt_d    = fcnt_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (src_enable) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                    pat_d   = pattern_sel;
                    solid_d = solid_level;
                end
            end
            ST_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d   = ST_ACTIVE;
                    cnt_d     = '0;
                    x_d       = '0;
                    y_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d = x_q + XY_W'(1);
                    // Bar index tracks x without a divider.
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + BAR_CW'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q < Y_LAST) begin
                        state_d   = ST_ACTIVE;
                        y_d       = y_q + XY_W'(1);
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = ST_VBLANK;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    if (src_enable) begin
                        state_d = ST_LEAD;
                        pat_d   = pattern_sel;
                        solid_d = solid_level;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        fval_d = (state_d == ST_LEAD) || (state_d == ST_ACTIVE) ||
                 (state_d == ST_HBLANK) || (state_d == ST_TAIL);
        lval_d = (state_d == ST_ACTIVE);
        busy_d = (state_d != ST_IDLE);
    end

    // Pattern RGB for the pixel about to be emitted, then GRBG component select.
    always_comb begin
        comp_r = '0;
        comp_g = '0;
        comp_b = '0;
        case (pat_q)
            2'd0: begin
                comp_r = solid_q;
                comp_g = solid_q;
                comp_b = solid_q;
            end
            2'd1: begin
                comp_r = x_d[DATA_W-1:0];
                comp_g = x_d[DATA_W-1:0];
                comp_b = x_d[DATA_W-1:0];
            end
            2'd2: begin
                comp_r = bar_idx_d[2] ? FULL : '0;
                comp_g = bar_idx_d[1] ? FULL : '0;
                comp_b = bar_idx_d[0] ? FULL : '0;
            end
            default: begin
                comp_r = (x_d[4] ^ y_d[4] ^ fcnt_q[0]) ? FULL : '0;
                comp_g = comp_r;
                comp_b = comp_r;
            end
        endcase

        if (!y_d[0]) begin
            pix_raw = x_d[0] ? comp_r : comp_g;
        end else begin
            pix_raw = x_d[0] ? comp_g : comp_b;
        end
    end

`ifdef SRC_LFSR_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16/14/13/11, stepping once per emitted active pixel.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = lval_d ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
        pix_out = pix_raw ^ {{(DATA_W-2){1'b0}}, lfsr_q[1:0]};
    end

    always_ff @(posedge CCD_PIXCLK or negedge RESET_SYS_N) begin
        if (!RESET_SYS_N) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        pix_out = pix_raw;
    end
`endif

    always_comb begin
        data_d = lval_d ? pix_out : '0;
    end

    assign CCD_DATA   = data_q;
    assign CCD_FVAL   = fval_q;
    assign CCD_LVAL   = lval_q;
    assign src_xcont  = x_q;
    assign src_ycont  = y_q;
    assign frame_done = done_q;
    assign src_busy   = busy_q;

endmodule

// File: tb/tb_bayer_stream_source.sv
// Directed bench for bayer_stream_source: frame timing, patterns, enable/reset behaviour.
module tb_bayer_stream_source;

    localparam int unsigned TB_HA = 16;
    localparam int unsigned TB_HB = 4;
    localparam int unsigned TB_VA = 4;
    localparam int unsigned TB_VB = 2;
    localparam int unsigned TB_LD = 2;
    localparam int unsigned TB_TL = 2;
    localparam int FV_HI = TB_LD + TB_VA * (TB_HA + TB_HB) + TB_TL;   // 84
    localparam int FV_LO = TB_VB * (TB_HA + TB_HB);                   // 40

    typedef struct packed {
        logic [9:0]  d;
        logic [12:0] x;
        logic [12:0] y;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_enable;
    logic [1:0]  pattern_sel;
    logic [9:0]  solid_level;
    logic [9:0]  CCD_DATA;
    logic        CCD_FVAL;
    logic        CCD_LVAL;
    logic [12:0] src_xcont;
    logic [12:0] src_ycont;
    logic        frame_done;
    logic        src_busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   fc = 0;
    pix_t q[$];
    pix_t mon_e;

    bayer_stream_source #(
        .H_ACTIVE(TB_HA), .H_BLANK(TB_HB), .V_ACTIVE(TB_VA),
        .V_BLANK(TB_VB), .FV_LEAD(TB_LD), .FV_TAIL(TB_TL)
    ) dut (
        .CCD_PIXCLK (clk),
        .RESET_SYS_N(rst_n),
        .src_enable (src_enable),
        .pattern_sel(pattern_sel),
        .solid_level(solid_level),
        .CCD_DATA   (CCD_DATA),
        .CCD_FVAL   (CCD_FVAL),
        .CCD_LVAL   (CCD_LVAL),
        .src_xcont  (src_xcont),
        .src_ycont  (src_ycont),
        .frame_done (frame_done),
        .src_busy   (src_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference GRBG sample for one pixel of one pattern.
    function automatic logic [9:0] exp_pix(input int pat, input logic [9:0] solid,
                                           input int x, input int y, input int fcnt);
        logic [9:0] r, g, b;
        int bi;
        bi = x / (TB_HA / 8);
        case (pat)
            0: begin r = solid; g = solid; b = solid; end
            1: begin r = 10'(x); g = 10'(x); b = 10'(x); end
            2: begin
                r = ((bi & 4) != 0) ? 10'h3FF : 10'h000;
                g = ((bi & 2) != 0) ? 10'h3FF : 10'h000;
                b = ((bi & 1) != 0) ? 10'h3FF : 10'h000;
            end
            default: begin
                r = ((((x >> 4) ^ (y >> 4) ^ fcnt) & 1) != 0) ? 10'h3FF : 10'h000;
                g = r;
                b = r;
            end
        endcase
        if (y % 2 == 0) return (x % 2 == 0) ? g : r;
        else            return (x % 2 == 0) ? b : g;
    endfunction

    task automatic push_frame(input int pat, input logic [9:0] solid, input int fcnt);
        for (int y = 0; y < int'(TB_VA); y++) begin
            for (int x = 0; x < int'(TB_HA); x++) begin
                q.push_back('{d: exp_pix(pat, solid, x, y, fcnt), x: 13'(x), y: 13'(y)});
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(CCD_DATA),   32'd0);
        check({tag, "_fval"},  32'(CCD_FVAL),   32'd0);
        check({tag, "_lval"},  32'(CCD_LVAL),   32'd0);
        check({tag, "_x"},     32'(src_xcont),  32'd0);
        check({tag, "_y"},     32'(src_ycont),  32'd0);
        check({tag, "_done"},  32'(frame_done), 32'd0);
        check({tag, "_busy"},  32'(src_busy),   32'd0);
    endtask

    task automatic wait_fval_rise(input int budget);
        int n;
        n = 0;
        while (CCD_FVAL !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fval_rise", 32'(CCD_FVAL), 32'd1);
    endtask

    // Entered on the first FVAL-high sample; returns on the first FVAL-low sample.
    task automatic measure_frame(input int chg_line, input logic chg_en,
                                 input logic [1:0] chg_pat, input logic [9:0] chg_solid);
        int hi, lines, lv, bad, n;
        logic prev;
        bit applied;
        hi = 0; lines = 0; lv = 0; bad = 0; n = 0; prev = 1'b0; applied = 1'b0;
        while (CCD_FVAL === 1'b1 && n < 400) begin
            hi++;
            if (CCD_LVAL === 1'b1) begin
                lv++;
                if (!prev) lines++;
                if (!applied && int'(src_ycont) == chg_line) begin
                    src_enable  = chg_en;
                    pattern_sel = chg_pat;
                    solid_level = chg_solid;
                    applied     = 1'b1;
                end
            end else if (CCD_DATA !== 10'd0) begin
                bad++;
            end
            prev = CCD_LVAL;
            @(negedge clk);
            n++;
        end
        check("fval_high_cycles", 32'(hi), 32'(FV_HI));
        check("lval_pulses", 32'(lines), 32'(TB_VA));
        check("lval_cycles", 32'(lv), 32'(TB_VA * TB_HA));
        check("data_nonzero_blank", 32'(bad), 32'd0);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("pix_queue_drained", 32'(q.size()), 32'd0);
        fc++;
    endtask

    // Entered on the first FVAL-low sample; returns on the next FVAL-high sample.
    task automatic measure_low();
        int lo, extra, n;
        lo = 0; extra = 0; n = 0;
        while (CCD_FVAL !== 1'b1 && n < 200) begin
            lo++;
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) extra++;
        end
        check("fval_low_cycles", 32'(lo), 32'(FV_LO));
        check("frame_done_extra", 32'(extra), 32'd0);
    endtask

    // Pixel monitor: every LVAL-high sample is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && CCD_LVAL === 1'b1) begin
            if (q.size() == 0) begin
                check("pix_unexpected", 32'd0, 32'd1);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("pix_data_y%0d_x%0d", mon_e.y, mon_e.x), 32'(CCD_DATA), 32'(mon_e.d));
                check("pix_x", 32'(src_xcont), 32'(mon_e.x));
                check("pix_y", 32'(src_ycont), 32'(mon_e.y));
            end
        end
    end

    initial begin
        int n, busy_cyc;
        rst_n       = 1'b0;
        src_enable  = 1'b0;
        pattern_sel = 2'd2;
        solid_level = 10'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Frame 0: colour bars
        src_enable = 1'b1;
        #2 rst_n = 1'b1;
        wait_fval_rise(10);
        check("lead_lval", 32'(CCD_LVAL), 32'd0);
        check("lead_busy", 32'(src_busy), 32'd1);
        push_frame(2, 10'd0, fc);
        measure_frame(-1, 1'b1, 2'd2, 10'd0);
        pattern_sel = 2'd3;
        measure_low();

        // Frame 1: checker with frame counter odd
        push_frame(3, 10'd0, fc);
        measure_frame(-1, 1'b1, 2'd3, 10'd0);
        pattern_sel = 2'd1;
        measure_low();

        // Frame 2: ramp
        push_frame(1, 10'd0, fc);
        measure_frame(-1, 1'b1, 2'd1, 10'd0);
        pattern_sel = 2'd0;
        solid_level = 10'h155;
        measure_low();

        // Frame 3: solid, with pattern/level changed mid-frame
        push_frame(0, 10'h155, fc);
        measure_frame(1, 1'b1, 2'd2, 10'h2AA);
        measure_low();

        // Frame 4: bars picked up from the mid-frame change; enable dropped at line 2
        push_frame(2, 10'd0, fc);
        measure_frame(2, 1'b0, 2'd2, 10'h2AA);
        busy_cyc = 0;
        n = 0;
        while (src_busy === 1'b1 && n < 100) begin
            check("vblank_fval_low", 32'(CCD_FVAL), 32'd0);
            busy_cyc++;
            @(negedge clk);
            n++;
        end
        check("vblank_then_idle_cycles", 32'(busy_cyc), 32'(FV_LO));
        check("idle_busy", 32'(src_busy), 32'd0);
        repeat (10) @(negedge clk);
        check("idle_fval_stays_low", 32'(CCD_FVAL), 32'd0);
        check("idle_busy_stays_low", 32'(src_busy), 32'd0);

        // Asynchronous reset in the middle of a line
        pattern_sel = 2'd1;
        src_enable  = 1'b1;
        wait_fval_rise(10);
        push_frame(1, 10'd0, fc);
        n = 0;
        while (!(CCD_LVAL === 1'b1 && src_xcont == 13'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_mid_line", 32'(src_xcont), 32'd5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        q.delete();
        fc = 0;
        repeat (2) @(negedge clk);
        pattern_sel = 2'd2;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_lead_fval", 32'(CCD_FVAL), 32'd1);
        check("post_reset_lead_busy", 32'(src_busy), 32'd1);
        check("post_reset_lead_lval", 32'(CCD_LVAL), 32'd0);
        push_frame(2, 10'd0, fc);
        measure_frame(-1, 1'b1, 2'd2, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
